digit_serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple-carry slice and a registered carry. It trades latency for area against the full-width ripple-carry adder and adds subtraction, signed-overflow detection and a start/done handshake. It sits in the datapath wherever a wide add is needed but a full-width combinational carry chain is not affordable.

---
 rtl/digit_serial_adder_pkg.sv | 16 +
 rtl/digit_serial_adder_cpa_slice.sv | 26 ++
 rtl/digit_serial_adder.sv | 125 ++++++++++++
 tb/tb_digit_serial_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types for the digit-serial adder/subtractor.
// FSM state encoding and counter sizing helper.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // A one-digit operation still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_cpa_slice.sv
// DIGIT-bit ripple-carry slice built from full-adder cells.
// Exposes the carry into the top bit for overflow detection.
module cpa_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end

    assign c_out    = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/sub: one DIGIT-bit slice, LSB digit first.
// Start/done handshake, carry-out and signed overflow.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cm;
    logic [WIDTH-1:0] acc_next;

    cpa_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a       (a_q[DIGIT-1:0]),
        .b       (b_q[DIGIT-1:0]),
        .c_in    (carry_q),
        .s       (dig_s),
        .c_out   (dig_co),
        .c_msb_in(dig_cm)
    );

    // New digit enters at the MSB end; after NDIG shifts it is LSB-aligned.
    assign acc_next = (acc_q >> DIGIT)
                    | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = c_in ^ sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = dig_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    s_d     = acc_next;
                    c_out_d = dig_co;
                    ovf_d   = dig_cm ^ dig_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: DIGIT 1, 4 and 16 side by side,
// directed corners plus random ops against an arithmetic model.
module tb_digit_serial_adder;

    localparam int W  = 16;
    localparam int NI = 3;
    localparam int DIGS[NI] = '{1, 4, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic         start_v[NI];
    logic         sub_v[NI];
    logic         cin_v[NI];
    logic [W-1:0] a_v[NI];
    logic [W-1:0] b_v[NI];
    logic         busy_v[NI];
    logic         done_v[NI];
    logic [W-1:0] s_v[NI];
    logic         co_v[NI];
    logic         ovf_v[NI];

    int n_chk = 0;
    int n_pass = 0;

    digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c_in(cin_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .s(s_v[0]), .c_out(co_v[0]), .ovf(ovf_v[0])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c_in(cin_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .s(s_v[1]), .c_out(co_v[1]), .ovf(ovf_v[1])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_v[2]), .b(b_v[2]), .c_in(cin_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .s(s_v[2]), .c_out(co_v[2]), .ovf(ovf_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // True-integer reference: wide sums, signed range test for overflow.
    function automatic void model(input logic sub, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic cin,
                                  output logic [W-1:0] s, output logic co,
                                  output logic ovf);
        int ua, ub, sa, sb, ci, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(cin);
        if (!sub) begin
            r  = ua + ub + ci;
            co = (r >= 65536);
            sr = sa + sb + ci;
        end else begin
            r  = ua - ub - ci;
            co = (r >= 0);
            sr = sa - sb - ci;
        end
        s   = r[W-1:0];
        ovf = (sr < -32768) || (sr > 32767);
    endfunction

    task automatic run_op(input int k, input logic sub, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co,
                          output logic ovf, output int lat, output int bcnt);
        @(negedge clk);
        start_v[k] = 1'b1;
        sub_v[k]   = sub;
        a_v[k]     = a;
        b_v[k]     = b;
        cin_v[k]   = cin;
        lat  = 0;
        bcnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            start_v[k] = 1'b0;
            if (busy_v[k]) bcnt++;
            if (done_v[k]) break;
        end
        s   = s_v[k];
        co  = co_v[k];
        ovf = ovf_v[k];
    endtask

    task automatic op_exp(input int k, input string tag, input logic sub,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es,
                          input logic eco, input logic eovf);
        logic [W-1:0] s;
        logic co, ov;
        int lat, bcnt;
        run_op(k, sub, a, b, cin, s, co, ov, lat, bcnt);
        check({tag, "_s"},    32'(s),    32'(es));
        check({tag, "_cout"}, 32'(co),   32'(eco));
        check({tag, "_ovf"},  32'(ov),   32'(eovf));
        check({tag, "_lat"},  32'(lat),  32'(W / DIGS[k] + 1));
        check({tag, "_busy"}, 32'(bcnt), 32'(W / DIGS[k]));
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_busy"}, 32'(busy_v[k]), 32'd0);
        check({tag, "_done"}, 32'(done_v[k]), 32'd0);
        check({tag, "_s"},    32'(s_v[k]),    32'd0);
        check({tag, "_cout"}, 32'(co_v[k]),   32'd0);
        check({tag, "_ovf"},  32'(ovf_v[k]),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, es, hold_s, s1, s2;
        logic rsub, rcin, eco, eovf, co2;
        int lat, d1, d2, ndone;

        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0;
            sub_v[k]   = 1'b0;
            cin_v[k]   = 1'b0;
            a_v[k]     = '0;
            b_v[k]     = '0;
        end

        #1;
        for (int k = 0; k < NI; k++) check_zero(k, "reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) check_zero(k, "post_reset");

        for (int k = 0; k < NI; k++) begin
            op_exp(k, "add_ff_1",    1'b0, 16'h00FF, 16'h0001, 1'b0,
                   16'h0100, 1'b0, 1'b0);
            op_exp(k, "add_wrap",    1'b0, 16'hFFFF, 16'h0001, 1'b0,
                   16'h0000, 1'b1, 1'b0);
            op_exp(k, "add_ovf",     1'b0, 16'h7FFF, 16'h0001, 1'b0,
                   16'h8000, 1'b0, 1'b1);
            op_exp(k, "sub_borrow",  1'b1, 16'h0005, 16'h0007, 1'b0,
                   16'hFFFE, 1'b0, 1'b0);
            op_exp(k, "sub_bin",     1'b1, 16'h0005, 16'h0007, 1'b1,
                   16'hFFFD, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("idle_hold_s", 32'(s_v[1]), 32'hFFFD);

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        start_v[1] = 1'b1;
        sub_v[1]   = 1'b0;
        cin_v[1]   = 1'b0;
        a_v[1]     = 16'h1234;
        b_v[1]     = 16'h1111;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            start_v[1] = (lat == 2);
            if (lat == 2) begin
                a_v[1]   = 16'hFFFF;
                b_v[1]   = 16'hFFFF;
                sub_v[1] = 1'b1;
            end
            if (done_v[1]) break;
        end
        check("ign_s",   32'(s_v[1]),  32'h2345);
        check("ign_lat", 32'(lat),     32'd5);
        check("ign_ovf", 32'(ovf_v[1]), 32'd0);

        // start held high through DONE: back-to-back second op
        repeat (2) @(negedge clk);
        start_v[1] = 1'b1;
        sub_v[1]   = 1'b0;
        cin_v[1]   = 1'b0;
        a_v[1]     = 16'h0010;
        b_v[1]     = 16'h0020;
        lat = 0;
        d1 = 0;
        d2 = 0;
        s1 = '0;
        s2 = '0;
        co2 = 1'b0;
        while (lat < 50 && d2 == 0) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                a_v[1]   = 16'h1000;
                b_v[1]   = 16'h0001;
                sub_v[1] = 1'b1;
            end
            if (d1 != 0 && lat == d1 + 1) start_v[1] = 1'b0;
            if (done_v[1]) begin
                if (d1 == 0) begin
                    d1 = lat;
                    s1 = s_v[1];
                end else begin
                    d2 = lat;
                    s2 = s_v[1];
                    co2 = co_v[1];
                end
            end
        end
        start_v[1] = 1'b0;
        check("b2b_d1",   32'(d1),  32'd5);
        check("b2b_s1",   32'(s1),  32'h0030);
        check("b2b_d2",   32'(d2),  32'd10);
        check("b2b_s2",   32'(s2),  32'h0FFF);
        check("b2b_cout", 32'(co2), 32'd1);

        // async reset mid-RUN: outputs clear at once, no done afterwards
        repeat (2) @(negedge clk);
        start_v[1] = 1'b1;
        a_v[1]     = 16'h4321;
        b_v[1]     = 16'h0001;
        sub_v[1]   = 1'b0;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy_v[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero(1, "mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[1]) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        check("rst_s_held",  32'(s_v[1]), 32'd0);

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra   = W'($urandom);
                rb   = W'($urandom);
                rsub = 1'($urandom_range(0, 1));
                rcin = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
                if ($urandom_range(0, 7) == 0) rb = 16'h8000;
                model(rsub, ra, rb, rcin, es, eco, eovf);
                op_exp(k, "rand", rsub, ra, rb, rcin, es, eco, eovf);
            end
        end

        hold_s = s_v[0];
        repeat (2) @(negedge clk);
        check("final_hold", 32'(s_v[0]), 32'(hold_s));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
